multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 44 ++++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if -- bundle between the multicycle control unit and
// its datapath.
//   Control/Funct3/Funct7_5 : instruction fields from the instruction register
//   Zero                    : ALU zero flag
//   Mem_Ready               : memory completion handshake
//   PC_Write..Illegal       : datapath strobes / selects
//   AluControl              : ALU operation (0000 AND, 0001 OR, 0010 ADD, 0110 SUB)
//   State                   : current FSM state
//   Instr_Count             : retired-instruction counter
// modport master = control unit, modport slave = datapath side.
interface multicycle_control_if;
    logic [6:0]  Control;
    logic [2:0]  Funct3;
    logic        Funct7_5;
    logic        Zero;
    logic        Mem_Ready;
    logic        PC_Write;
    logic        PC_Src;
    logic        IR_Write;
    logic        IorD;
    logic        Mem_Read;
    logic        Mem_Write;
    logic        ALU_Src;
    logic        Reg_Write;
    logic        Mem_To_Reg;
    logic        Illegal;
    logic [3:0]  AluControl;
    logic [2:0]  State;
    logic [31:0] Instr_Count;

    modport master (
        input  Control, Funct3, Funct7_5, Zero, Mem_Ready,
        output PC_Write, PC_Src, IR_Write, IorD, Mem_Read, Mem_Write,
               ALU_Src, Reg_Write, Mem_To_Reg, Illegal, AluControl,
               State, Instr_Count
    );

    modport slave (
        output Control, Funct3, Funct7_5, Zero, Mem_Ready,
        input  PC_Write, PC_Src, IR_Write, IorD, Mem_Read, Mem_Write,
               ALU_Src, Reg_Write, Mem_To_Reg, Illegal, AluControl,
               State, Instr_Count
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control -- FSM controller for a multicycle RV32 subset
// (R/I ALU ops, LW, SW, BEQ/BNE).
//   Clock : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : multicycle_control_if.master (instruction fields, Zero,
//           Mem_Ready in; strobes, AluControl, State, Instr_Count out)
// Flow: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH.
// Outputs are combinational from the registered state and latched fields.
module multicycle_control (
    input  logic                   Clock,
    input  logic                   Reset,
    multicycle_control_if.master   bus
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } state_e;

    typedef enum logic [2:0] {K_NONE, K_R, K_I, K_LD, K_ST, K_BR} kind_e;

    typedef struct packed {
        logic       legal;
        kind_e      kind;
        logic [3:0] alu;
    } dec_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    function automatic dec_t f_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f75);
        dec_t d;
        d.legal = 1'b0;
        d.kind  = K_NONE;
        d.alu   = ALU_ADD;
        case (op)
            OP_R: begin
                case (f3)
                    3'b000: begin d.legal = 1'b1; d.kind = K_R; d.alu = f75 ? ALU_SUB : ALU_ADD; end
                    3'b111: begin d.legal = 1'b1; d.kind = K_R; d.alu = ALU_AND; end
                    3'b110: begin d.legal = 1'b1; d.kind = K_R; d.alu = ALU_OR;  end
                    default: ;
                endcase
            end
            OP_I: begin
                case (f3)
                    3'b000: begin d.legal = 1'b1; d.kind = K_I; d.alu = ALU_ADD; end
                    3'b111: begin d.legal = 1'b1; d.kind = K_I; d.alu = ALU_AND; end
                    3'b110: begin d.legal = 1'b1; d.kind = K_I; d.alu = ALU_OR;  end
                    default: ;
                endcase
            end
            OP_LD: if (f3 == 3'b010) begin d.legal = 1'b1; d.kind = K_LD; end
            OP_ST: if (f3 == 3'b010) begin d.legal = 1'b1; d.kind = K_ST; end
            OP_BR: if (f3 == 3'b000 || f3 == 3'b001) begin
                d.legal = 1'b1; d.kind = K_BR; d.alu = ALU_SUB;
            end
            default: ;
        endcase
        return d;
    endfunction

    state_e      r_state;
    logic [6:0]  r_op;
    logic [2:0]  r_f3;
    logic        r_f75;
    logic [31:0] r_count;

    state_e      w_next;
    dec_t        w_dec_live;   // decode of the IR as it stands (used in DECODE)
    dec_t        w_dec_lat;    // decode of the fields latched leaving DECODE
    logic        w_retire;
    logic        w_taken;
    logic        w_pc_write, w_pc_src, w_ir_write, w_iord, w_mem_read;
    logic        w_mem_write, w_alu_src, w_reg_write, w_mem_to_reg, w_illegal;
    logic [3:0]  w_alu;

    assign w_dec_live = f_decode(bus.Control, bus.Funct3, bus.Funct7_5);
    assign w_dec_lat  = f_decode(r_op, r_f3, r_f75);
    // BEQ is funct3 000, BNE is 001: bit 0 selects the Zero polarity
    assign w_taken    = r_f3[0] ? ~bus.Zero : bus.Zero;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= FETCH;
            r_op    <= '0;
            r_f3    <= '0;
            r_f75   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op  <= bus.Control;
                r_f3  <= bus.Funct3;
                r_f75 <= bus.Funct7_5;
            end
            if (w_retire) r_count <= r_count + 32'd1;
        end
    end

    always_comb begin
        w_next       = FETCH;
        w_retire     = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        w_alu        = ALU_ADD;
        case (r_state)
            FETCH: begin
                w_mem_read = 1'b1;
                if (bus.Mem_Ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = DECODE;
                end else begin
                    w_next     = FETCH;
                end
            end
            DECODE: begin
                if (!w_dec_live.legal) begin
                    w_illegal = 1'b1;
                    w_next    = FETCH;
                end else begin
                    w_next    = EXECUTE;
                end
            end
            EXECUTE: begin
                w_alu     = w_dec_lat.alu;
                w_alu_src = (w_dec_lat.kind == K_I) || (w_dec_lat.kind == K_LD) ||
                            (w_dec_lat.kind == K_ST);
                case (w_dec_lat.kind)
                    K_BR: begin
                        w_pc_write = w_taken;
                        w_pc_src   = w_taken;
                        w_retire   = 1'b1;
                        w_next     = FETCH;
                    end
                    K_LD, K_ST: w_next = MEMORY;
                    default:    w_next = WRITEBACK;
                endcase
            end
            MEMORY: begin
                w_iord      = 1'b1;
                w_mem_read  = (w_dec_lat.kind == K_LD);
                w_mem_write = (w_dec_lat.kind == K_ST);
                if (bus.Mem_Ready) begin
                    w_next   = (w_dec_lat.kind == K_LD) ? WRITEBACK : FETCH;
                    w_retire = (w_dec_lat.kind == K_ST);
                end else begin
                    w_next   = MEMORY;
                end
            end
            WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (w_dec_lat.kind == K_LD);
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    // Strobes are forced low while Reset is held, so FETCH's Mem_Read does
    // not leak out during reset.
    assign bus.PC_Write    = w_pc_write   & ~Reset;
    assign bus.PC_Src      = w_pc_src     & ~Reset;
    assign bus.IR_Write    = w_ir_write   & ~Reset;
    assign bus.IorD        = w_iord       & ~Reset;
    assign bus.Mem_Read    = w_mem_read   & ~Reset;
    assign bus.Mem_Write   = w_mem_write  & ~Reset;
    assign bus.ALU_Src     = w_alu_src    & ~Reset;
    assign bus.Reg_Write   = w_reg_write  & ~Reset;
    assign bus.Mem_To_Reg  = w_mem_to_reg & ~Reset;
    assign bus.Illegal     = w_illegal    & ~Reset;
    assign bus.AluControl  = w_alu;
    assign bus.State       = r_state;
    assign bus.Instr_Count = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    multicycle_control_if bus();

    multicycle_control dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 32'd0;

    // strobe vector bit positions
    localparam int PCW = 9, PCS = 8, IRW = 7, IORD = 6, MRD = 5;
    localparam int MWR = 4, ASRC = 3, RW = 2, M2R = 1, ILL = 0;

    logic [9:0] obs;
    assign obs = {bus.PC_Write, bus.PC_Src, bus.IR_Write, bus.IorD, bus.Mem_Read,
                  bus.Mem_Write, bus.ALU_Src, bus.Reg_Write, bus.Mem_To_Reg, bus.Illegal};

    typedef struct {
        logic [2:0] st;
        logic [9:0] strb;
        logic [3:0] alu;
        logic       rdy;
    } cyc_t;
    cyc_t exp_q[$];

    // Reference classification: which instruction class, legal or not, and
    // which ALU op it asks for.  kind: 0 none, 1 R, 2 I, 3 LW, 4 SW, 5 branch
    task automatic ref_class(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             output bit legal, output int kind, output logic [3:0] alu);
        legal = 0; kind = 0; alu = 4'b0010;
        if (op == 7'h33 || op == 7'h13) begin
            kind = (op == 7'h33) ? 1 : 2;
            if (f3 == 3'd0) begin legal = 1; alu = (op == 7'h33 && f75) ? 4'b0110 : 4'b0010; end
            else if (f3 == 3'd7) begin legal = 1; alu = 4'b0000; end
            else if (f3 == 3'd6) begin legal = 1; alu = 4'b0001; end
        end else if (op == 7'h03 && f3 == 3'd2) begin legal = 1; kind = 3; end
        else if (op == 7'h23 && f3 == 3'd2) begin legal = 1; kind = 4; end
        else if (op == 7'h63 && f3 <= 3'd1) begin legal = 1; kind = 5; alu = 4'b0110; end
        if (!legal) kind = 0;
    endtask

    // Runs one instruction from FETCH; called at least 1ns after a rising edge
    // with the FSM in FETCH.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic zero, input int fs, input int ms);
        bit legal; int kind; logic [3:0] alu;
        logic [9:0] s; bit taken;
        cyc_t c;
        ref_class(op, f3, f75, legal, kind, alu);
        exp_q.delete();
        for (int i = 0; i < fs; i++) exp_q.push_back('{3'd0, 10'(1 << MRD), 4'b0010, 1'b0});
        exp_q.push_back('{3'd0, 10'((1 << MRD) | (1 << IRW) | (1 << PCW)), 4'b0010, 1'b1});
        exp_q.push_back('{3'd1, legal ? 10'd0 : 10'(1 << ILL), 4'b0010, 1'($urandom_range(1))});
        if (legal) begin
            s = (kind == 2 || kind == 3 || kind == 4) ? 10'(1 << ASRC) : 10'd0;
            taken = (kind == 5) && ((f3 == 3'd0) ? zero : !zero);
            if (taken) s = s | 10'((1 << PCW) | (1 << PCS));
            exp_q.push_back('{3'd2, s, alu, 1'($urandom_range(1))});
            if (kind == 3 || kind == 4) begin
                s = 10'((1 << IORD) | ((kind == 3) ? (1 << MRD) : (1 << MWR)));
                for (int i = 0; i < ms; i++) exp_q.push_back('{3'd3, s, 4'b0010, 1'b0});
                exp_q.push_back('{3'd3, s, 4'b0010, 1'b1});
            end
            if (kind == 1 || kind == 2 || kind == 3)
                exp_q.push_back('{3'd4, 10'(1 << RW) | ((kind == 3) ? 10'(1 << M2R) : 10'd0),
                                  4'b0010, 1'($urandom_range(1))});
            exp_cnt = exp_cnt + 32'd1;
        end
        bus.Control = op; bus.Funct3 = f3; bus.Funct7_5 = f75; bus.Zero = zero;
        for (int i = 0; i < exp_q.size(); i++) begin
            c = exp_q[i];
            bus.Mem_Ready = c.rdy;
            @(negedge Clock);
            checks++;
            if ({bus.State, obs, bus.AluControl} !== {c.st, c.strb, c.alu}) begin
                failures++;
                $display("FAIL %s cyc%0d: state/strobes/alu got %0d/%b/%b want %0d/%b/%b",
                         nm, i, bus.State, obs, bus.AluControl, c.st, c.strb, c.alu);
            end
            @(posedge Clock); #1;
        end
        checks++;
        if (bus.State !== 3'd0 || bus.Instr_Count !== exp_cnt) begin
            failures++;
            $display("FAIL %s end: state=%0d count=%h want state=0 count=%h",
                     nm, bus.State, bus.Instr_Count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.Mem_Ready = 1'b1; bus.Zero = 1'b0;
        bus.Control = 7'h33; bus.Funct3 = 3'd0; bus.Funct7_5 = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.State !== 3'd0 || bus.Instr_Count !== 32'd0 || obs !== 10'd0) begin
            failures++;
            $display("FAIL reset: state=%0d count=%h strobes=%b want 0/0/0",
                     bus.State, bus.Instr_Count, obs);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_add();
        logic [31:0] w;
        w = 32'h002081B3;
        run_instr("add", w[6:0], w[14:12], w[30], 1'b0, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr("lw_stall", 7'h03, 3'd2, 1'b0, 1'b0, 0, 3);
        run_instr("lw_fstall", 7'h03, 3'd2, 1'b1, 1'b1, 2, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 7'h63, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr("beq_z0", 7'h63, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("bne_z0", 7'h63, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("bne_z1", 7'h63, 3'd1, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("ill_7f", 7'h7F, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("ill_rf3", 7'h33, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("ill_lwf3", 7'h03, 3'd0, 1'b0, 1'b0, 1, 0);
    endtask

    task automatic test_sw_reset();
        bus.Control = 7'h23; bus.Funct3 = 3'd2; bus.Funct7_5 = 1'b0; bus.Zero = 1'b0;
        bus.Mem_Ready = 1'b1;
        @(posedge Clock); #1;           // DECODE
        bus.Mem_Ready = 1'b0;
        @(posedge Clock); #1;           // EXECUTE
        @(posedge Clock); #1;           // MEMORY, stalled
        checks++;
        if (bus.State !== 3'd3 || bus.Mem_Write !== 1'b1 || bus.Instr_Count === 32'd0) begin
            failures++;
            $display("FAIL sw_stall: state=%0d mem_write=%b count=%h want 3/1/nonzero",
                     bus.State, bus.Mem_Write, bus.Instr_Count);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (bus.State !== 3'd0 || bus.Mem_Write !== 1'b0 || bus.Instr_Count !== 32'd0 ||
            obs !== 10'd0) begin
            failures++;
            $display("FAIL sw_async_reset: state=%0d mem_write=%b count=%h strobes=%b want 0/0/0/0",
                     bus.State, bus.Mem_Write, bus.Instr_Count, obs);
        end
        exp_cnt = 32'd0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        run_instr("after_reset", 7'h23, 3'd2, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic test_wrap();
        force dut.r_count = 32'hFFFF_FFFF;
        #1 release dut.r_count;
        #1;
        exp_cnt = 32'hFFFF_FFFF;
        checks++;
        if (bus.Instr_Count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload: count=%h want ffffffff", bus.Instr_Count);
        end
        run_instr("sub_wrap", 7'h33, 3'd0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63;
        for (int n = 0; n < 60; n++) begin
            ops[5] = 7'($urandom);
            op = ops[$urandom_range(5)];
            run_instr("rand", op, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(2)), int'($urandom_range(3)));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_illegal();
        test_sw_reset();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
